// File: rtl/branch_trace_oracle.sv
// Branch trace oracle: stores (pc, taken, target) records while idle, then replays
// them in program order, advancing whenever the IFU fetches the head record's PC.
module branch_trace_oracle #(
    parameter int DEPTH   = 256,
    parameter int AW      = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          load_en,
    input  logic [31:0]   load_pc,
    input  logic          load_taken,
    input  logic [31:0]   load_target,
    input  logic          start,
    input  logic          fetch_valid,
    input  logic [31:0]   fetch_pc,
    output logic          actual_valid,
    output logic [31:0]   actual_pc,
    output logic          actual_taken,
    output logic [31:0]   actual_target,
    output logic          busy,
    output logic          done,
    output logic          timeout_err,
    output logic          overflow,
    output logic [AW:0]   entries_loaded,
    output logic [AW:0]   entries_consumed
);

    localparam int SW  = $clog2(TIMEOUT) + 1;
    localparam int PW  = AW + 1;
    localparam logic [PW-1:0] DEPTH_C   = PW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [SW-1:0] TIMEOUT_C = SW'(TIMEOUT);
    localparam logic [SW-1:0] STALL_ONE = SW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [SW-1:0] stall_q, stall_d;
    logic          overflow_q, overflow_d;

    logic [64:0]   mem [DEPTH];
    logic [64:0]   head;
    logic          full;
    logic          wr_en;
    logic          match;

    assign full  = (wr_ptr_q == DEPTH_C);
    assign wr_en = (state_q == ST_IDLE) && load_en && !full && !clear;

    // Head is read combinationally so the checker sees it in the same cycle as fetch_pc.
    assign head  = mem[rd_ptr_q[AW-1:0]];
    assign match = (state_q == ST_RUN) && fetch_valid && (fetch_pc == head[64:33]);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        stall_d    = stall_q;
        overflow_d = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (load_en) begin
                    if (full) overflow_d = 1'b1;
                    else      wr_ptr_d   = wr_ptr_q + PTR_ONE;
                end
                // start sees the count including a record loaded on the same edge
                if (start) begin
                    rd_ptr_d = '0;
                    stall_d  = '0;
                    state_d  = (wr_ptr_d != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (match) begin
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                    stall_d  = '0;
                    if (rd_ptr_d == wr_ptr_q) state_d = ST_DONE;
                end else if (fetch_valid) begin
                    if (stall_q != TIMEOUT_C) stall_d = stall_q + STALL_ONE;
                    if (stall_d == TIMEOUT_C) state_d = ST_ERROR;
                end
            end
            default: ;
        endcase

        if (clear) begin
            state_d    = ST_IDLE;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            stall_d    = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            stall_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            stall_q    <= stall_d;
            overflow_q <= overflow_d;
        end
    end

    // Record storage needs no reset: only entries below wr_ptr are ever presented.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q[AW-1:0]] <= {load_pc, load_taken, load_target};
    end

    assign actual_valid     = (state_q == ST_RUN);
    assign actual_pc        = actual_valid ? head[64:33] : '0;
    assign actual_taken     = actual_valid ? head[32]    : 1'b0;
    assign actual_target    = actual_valid ? head[31:0]  : '0;
    assign busy             = (state_q == ST_RUN);
    assign done             = (state_q == ST_DONE);
    assign timeout_err      = (state_q == ST_ERROR);
    assign overflow         = overflow_q;
    assign entries_loaded   = wr_ptr_q;
    assign entries_consumed = rd_ptr_q;

endmodule
